// File: rtl/newspaper_pkg.sv
// Shared encodings for the newspaper vending block: FSM states, coin codes
// and the coin-to-credit conversion.
package newspaper_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Value of a coin code in 5c units; bad/no coin is worth nothing.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  coin_units = 2'd1;
            COIN_10: coin_units = 2'd2;
            default: coin_units = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/newspaper_stock_cnt.sv
// Paper stock counter: reload on refill, decrement on completed vend,
// sold_out flag straight from the register.
module newspaper_stock_cnt #(
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               refill_i,
    input  logic               dec_i,
    output logic [STOCK_W-1:0] stock_o,
    output logic               sold_out_o
);

    localparam logic [STOCK_W-1:0] INIT_C = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] ONE_C  = STOCK_W'(1);

    logic [STOCK_W-1:0] stock_q, stock_d;

    // Refill beats a same-cycle vend; the empty check keeps the count from wrapping.
    always_comb begin
        stock_d = stock_q;
        if (refill_i)
            stock_d = INIT_C;
        else if (dec_i && stock_q != '0)
            stock_d = stock_q - ONE_C;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stock_q <= INIT_C;
        else
            stock_q <= stock_d;
    end

    assign stock_o    = stock_q;
    assign sold_out_o = (stock_q == '0);

endmodule

// File: rtl/newspaper_vend_fsm.sv
// Newspaper vending controller: credits 5c/10c coins, requests a paper at
// PRICE, pays change / refunds in 5c pulses and rejects coins it cannot take.
module newspaper_vend_fsm
    import newspaper_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coinin,
    input  logic                outpaper,
    input  logic                cancel,
    input  logic                refill,
    output logic                newspaper,
    output logic                change_out,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          dbg_state_o,
    output logic [STOCK_W-1:0]  dbg_stock_o
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                vend_done;
    logic                coin_present;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] credit_after_vend;

    assign coin_present      = (coinin != COIN_NONE);
    assign coin_val          = CREDIT_W'(coin_units(coinin));
    assign credit_after_vend = credit_q - PRICE_C;

    // Coins are credited only in IDLE below PRICE, so credit tops out at PRICE+1.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        reject_d  = 1'b0;
        vend_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cancel && credit_q != '0) begin
                    state_d  = S_CHANGE;
                    reject_d = coin_present;
                end else if (credit_q >= PRICE_C) begin
                    reject_d = coin_present;
                    if (!sold_out)
                        state_d = S_VEND;
                end else if (coinin == COIN_BAD || sold_out) begin
                    reject_d = coin_present;
                end else begin
                    credit_d = credit_q + coin_val;
                end
            end
            S_VEND: begin
                reject_d = coin_present;
                if (outpaper) begin
                    vend_done = 1'b1;
                    credit_d  = credit_after_vend;
                    state_d   = (credit_after_vend != '0) ? S_CHANGE : S_IDLE;
                end else if (cancel) begin
                    state_d = S_CHANGE;
                end
            end
            S_CHANGE: begin
                reject_d = coin_present;
                credit_d = credit_q - ONE_C;
                if (credit_q <= ONE_C) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    newspaper_stock_cnt #(
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK)
    ) u_stock (
        .clk       (clk),
        .rst       (rst),
        .refill_i  (refill),
        .dec_i     (vend_done),
        .stock_o   (dbg_stock_o),
        .sold_out_o(sold_out)
    );

    assign newspaper   = (state_q == S_VEND);
    assign change_out  = (state_q == S_CHANGE);
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign dbg_state_o = state_q;

endmodule
